// File: rtl/fetch_queue.sv
// ============================================================================
//  Module      : fetch_queue
//  Description : Circular instruction queue between the I-cache and the issue
//                stage. Accepts instruction pairs and presents the two oldest
//                entries with zero latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fill_valid,
  input  logic [31:0]                fill_instr0,
  input  logic [31:0]                fill_instr1,
  output logic                       fill_ready,
  input  logic                       consume,
  input  logic                       rollback,
  input  logic                       flush,
  output logic [31:0]                instr1,
  output logic [31:0]                instr2,
  output logic                       valid1,
  output logic                       valid2,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stall_q, stall_d;

  logic          w_push;
  logic [1:0]    w_pop_req;
  logic [CW-1:0] w_pop_req_ext;
  logic [CW-1:0] w_pop_n;
  logic [CW-1:0] w_push_n;
  logic [AW-1:0] w_rd_nxt;
  logic [AW-1:0] w_wr_nxt;

  // Space for a whole pair is required; a same-cycle pop never helps.
  assign fill_ready = (count_q <= CW'(DEPTH - 2));
  assign w_push     = fill_valid && fill_ready;
  assign w_rd_nxt   = rd_ptr_q + AW'(1);
  assign w_wr_nxt   = wr_ptr_q + AW'(1);

  // Pop amount: requested width, clamped by occupancy so the queue never underflows.
  always_comb begin
    w_pop_req = 2'd0;
    if (consume) begin
      w_pop_req = rollback ? 2'd1 : 2'd2;
    end
    w_pop_req_ext = {{(CW-2){1'b0}}, w_pop_req};
    w_pop_n       = (count_q < w_pop_req_ext) ? count_q : w_pop_req_ext;
    w_push_n      = w_push ? CW'(2) : '0;
  end

  // Next-state for pointers, occupancy and the starvation counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q + w_pop_n[AW-1:0];
    wr_ptr_d = w_push ? (wr_ptr_q + AW'(2)) : wr_ptr_q;
    count_d  = count_q + w_push_n - w_pop_n;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    // Starvation is counted even in flush cycles and survives the flush.
    stall_d = stall_q;
    if (consume && !rollback && (count_q < CW'(2)) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage: the older instruction lands at wr_ptr, the younger right after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (w_push && !flush) begin
      mem_q[wr_ptr_q] <= fill_instr0;
      mem_q[w_wr_nxt] <= fill_instr1;
    end
  end

  // Head outputs; empty slots show a NOP bubble.
  always_comb begin
    valid1 = (count_q >= CW'(1));
    valid2 = (count_q >= CW'(2));
    instr1 = valid1 ? mem_q[rd_ptr_q] : 32'h0;
    instr2 = valid2 ? mem_q[w_rd_nxt] : 32'h0;
  end

  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue (DEPTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        fill_valid;
  logic [31:0] fill_instr0;
  logic [31:0] fill_instr1;
  logic        fill_ready;
  logic        consume;
  logic        rollback;
  logic        flush;
  logic [31:0] instr1;
  logic [31:0] instr2;
  logic        valid1;
  logic        valid2;
  logic [3:0]  count;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_stall = 16'd0;

  fetch_queue #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_valid   (fill_valid),
    .fill_instr0  (fill_instr0),
    .fill_instr1  (fill_instr1),
    .fill_ready   (fill_ready),
    .consume      (consume),
    .rollback     (rollback),
    .flush        (flush),
    .instr1       (instr1),
    .instr2       (instr2),
    .valid1       (valid1),
    .valid2       (valid2),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fill_valid = 1'b0; consume = 1'b0; rollback = 1'b0; flush = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    fill_valid = 1'b1; fill_instr0 = a; fill_instr1 = b;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    fill_instr0 = 32'h0; fill_instr1 = 32'h0;
    #3;
    if (instr1 !== 32'h0) begin n_fail++; $display("FAIL reset_instr1: got %h want 0", instr1); end n_tests++;
    if (instr2 !== 32'h0) begin n_fail++; $display("FAIL reset_instr2: got %h want 0", instr2); end n_tests++;
    if (valid1 !== 1'b0 || valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b want 00", valid1, valid2); end n_tests++;
    if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", fill_ready); end n_tests++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end n_tests++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end n_tests++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_push_pair();
    push_pair(32'h11, 32'h22);
    if (instr1 !== 32'h11) begin n_fail++; $display("FAIL push_instr1: got %h want 11", instr1); end n_tests++;
    if (instr2 !== 32'h22) begin n_fail++; $display("FAIL push_instr2: got %h want 22", instr2); end n_tests++;
    if (valid1 !== 1'b1 || valid2 !== 1'b1) begin n_fail++; $display("FAIL push_valid: got %b%b want 11", valid1, valid2); end n_tests++;
    if (count !== 4'd2) begin n_fail++; $display("FAIL push_count: got %0d want 2", count); end n_tests++;
  endtask

  task automatic test_rollback();
    push_pair(32'h33, 32'h44);
    if (count !== 4'd4) begin n_fail++; $display("FAIL rb_fill_count: got %0d want 4", count); end n_tests++;
    consume = 1'b1; rollback = 1'b1;
    tick();
    idle_inputs();
    if (instr1 !== 32'h22) begin n_fail++; $display("FAIL rb1_instr1: got %h want 22", instr1); end n_tests++;
    if (instr2 !== 32'h33) begin n_fail++; $display("FAIL rb1_instr2: got %h want 33", instr2); end n_tests++;
    if (count !== 4'd3) begin n_fail++; $display("FAIL rb1_count: got %0d want 3", count); end n_tests++;
    consume = 1'b1;
    tick();
    idle_inputs();
    if (instr1 !== 32'h44) begin n_fail++; $display("FAIL pop2_instr1: got %h want 44", instr1); end n_tests++;
    if (valid2 !== 1'b0) begin n_fail++; $display("FAIL pop2_valid2: got %b want 0", valid2); end n_tests++;
    if (instr2 !== 32'h0) begin n_fail++; $display("FAIL pop2_instr2: got %h want 0", instr2); end n_tests++;
    if (count !== 4'd1) begin n_fail++; $display("FAIL pop2_count: got %0d want 1", count); end n_tests++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL pop2_stall: got %0d want %0d", stall_cycles, exp_stall); end n_tests++;
  endtask

  task automatic test_underflow_stall();
    consume = 1'b1;
    tick();
    idle_inputs();
    exp_stall = exp_stall + 16'd1;
    if (count !== 4'd0) begin n_fail++; $display("FAIL uf_count: got %0d want 0", count); end n_tests++;
    if (valid1 !== 1'b0) begin n_fail++; $display("FAIL uf_valid1: got %b want 0", valid1); end n_tests++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL uf_stall: got %0d want %0d", stall_cycles, exp_stall); end n_tests++;
    consume = 1'b1;
    tick();
    idle_inputs();
    exp_stall = exp_stall + 16'd1;
    if (count !== 4'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 0", count); end n_tests++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL empty_pop_stall: got %0d want %0d", stall_cycles, exp_stall); end n_tests++;
  endtask

  task automatic test_full();
    for (int k = 0; k < 3; k++) push_pair(32'h100 + 32'(2*k), 32'h101 + 32'(2*k));
    if (count !== 4'd6 || fill_ready !== 1'b1) begin n_fail++; $display("FAIL full6: got count %0d ready %b want 6 1", count, fill_ready); end n_tests++;
    push_pair(32'h106, 32'h107);
    if (count !== 4'd8) begin n_fail++; $display("FAIL full8_count: got %0d want 8", count); end n_tests++;
    if (fill_ready !== 1'b0) begin n_fail++; $display("FAIL full8_ready: got %b want 0", fill_ready); end n_tests++;
    push_pair(32'hDEAD0, 32'hDEAD1);
    if (count !== 4'd8 || instr1 !== 32'h100) begin n_fail++; $display("FAIL full_ignore: got count %0d instr1 %h want 8 100", count, instr1); end n_tests++;
    fill_valid = 1'b1; fill_instr0 = 32'hDEAD2; fill_instr1 = 32'hDEAD3; consume = 1'b1;
    tick();
    idle_inputs();
    if (count !== 4'd6 || fill_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop: got count %0d ready %b want 6 1", count, fill_ready); end n_tests++;
    if (instr1 !== 32'h102 || instr2 !== 32'h103) begin n_fail++; $display("FAIL full_pop_data: got %h %h want 102 103", instr1, instr2); end n_tests++;
    push_pair(32'h200, 32'h201);
    fill_valid = 1'b1; fill_instr0 = 32'hDEAD4; fill_instr1 = 32'hDEAD5; consume = 1'b1; rollback = 1'b1;
    tick();
    idle_inputs();
    if (count !== 4'd7 || fill_ready !== 1'b0) begin n_fail++; $display("FAIL full7: got count %0d ready %b want 7 0", count, fill_ready); end n_tests++;
    if (instr1 !== 32'h103) begin n_fail++; $display("FAIL full7_instr1: got %h want 103", instr1); end n_tests++;
  endtask

  task automatic test_back_to_back();
    flush = 1'b1;
    tick();
    idle_inputs();
    if (count !== 4'd0) begin n_fail++; $display("FAIL b2b_flush_count: got %0d want 0", count); end n_tests++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL flush_keeps_stall: got %0d want %0d", stall_cycles, exp_stall); end n_tests++;
    push_pair(32'h1000, 32'h1001);
    for (int k = 1; k <= 10; k++) begin
      fill_valid = 1'b1; fill_instr0 = 32'h1000 + 32'(2*k); fill_instr1 = 32'h1001 + 32'(2*k);
      consume = 1'b1;
      tick();
      idle_inputs();
      if (instr1 !== 32'h1000 + 32'(2*k) || instr2 !== 32'h1001 + 32'(2*k)) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h %h want %h %h", k, instr1, instr2, 32'h1000 + 32'(2*k), 32'h1001 + 32'(2*k));
      end
      n_tests++;
      if (count !== 4'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 2", k, count); end n_tests++;
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    idle_inputs();
    push_pair(32'hA0, 32'hA1);
    push_pair(32'hA2, 32'hA3);
    if (count !== 4'd4) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 4", count); end n_tests++;
    flush = 1'b1; consume = 1'b1;
    fill_valid = 1'b1; fill_instr0 = 32'hBAD0; fill_instr1 = 32'hBAD1;
    tick();
    idle_inputs();
    if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end n_tests++;
    if (valid1 !== 1'b0 || instr1 !== 32'h0) begin n_fail++; $display("FAIL flush_head: got %b %h want 0 0", valid1, instr1); end n_tests++;
    push_pair(32'hC0, 32'hC1);
    if (instr1 !== 32'hC0 || instr2 !== 32'hC1 || count !== 4'd2) begin
      n_fail++; $display("FAIL flush_drop: got %h %h count %0d want c0 c1 2", instr1, instr2, count);
    end
    n_tests++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL flush_stall: got %0d want %0d", stall_cycles, exp_stall); end n_tests++;
  endtask

  task automatic test_async_reset();
    push_pair(32'hE0, 32'hE1);
    if (count !== 4'd4) begin n_fail++; $display("FAIL ar_pre_count: got %0d want 4", count); end n_tests++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_stall = 16'd0;
    if (instr1 !== 32'h0 || instr2 !== 32'h0) begin n_fail++; $display("FAIL ar_instr: got %h %h want 0 0", instr1, instr2); end n_tests++;
    if (valid1 !== 1'b0 || valid2 !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b%b want 00", valid1, valid2); end n_tests++;
    if (count !== 4'd0 || fill_ready !== 1'b1) begin n_fail++; $display("FAIL ar_count: got %0d ready %b want 0 1", count, fill_ready); end n_tests++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL ar_stall: got %0d want 0", stall_cycles); end n_tests++;
    tick();
    rst_n = 1'b1;
    push_pair(32'hF0, 32'hF1);
    if (instr1 !== 32'hF0 || instr2 !== 32'hF1 || count !== 4'd2) begin
      n_fail++; $display("FAIL ar_resume: got %h %h count %0d want f0 f1 2", instr1, instr2, count);
    end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_push_pair();
    test_rollback();
    test_underflow_stall();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 8, number of 32-bit instruction slots; power of two, minimum 4.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: fill_valid  input  1  I-cache presents an instruction pair this cycle.
REQ-005 Port: fill_instr0  input  32  older instruction of the fetched pair.
REQ-006 Port: fill_instr1  input  32  younger instruction of the fetched pair.
REQ-007 Port: fill_ready  output  1  queue can accept a pair this cycle.
REQ-008 Port: consume  input  1  issue stage takes instructions from the head this cycle.
REQ-009 Port: rollback  input  1  issue stage took only one instruction; qualifies consume.
REQ-010 Port: flush  input  1  synchronous discard of all queued instructions.
REQ-011 Port: instr1  output  32  head instruction, fed to the issue stage's first slot.
REQ-012 Port: instr2  output  32  head+1 instruction, fed to the issue stage's second slot.
REQ-013 Port: valid1  output  1  instr1 holds a real queued instruction.
REQ-014 Port: valid2  output  1  instr2 holds a real queued instruction.
REQ-015 Port: count  output  clog2(DEPTH)+1  number of occupied slots.
REQ-016 Port: stall_cycles  output  16  saturating count of cycles starved of a full pair.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH 32-bit entries with read pointer rd_ptr and write pointer wr_ptr of clog2(DEPTH) bits each; both wrap from DEPTH-1 to 0.
REQ-018 fill_ready SHALL be combinational: 1 when count <= DEPTH-2, else 0; it does not depend on consume in the same cycle.
REQ-019 Push: when fill_valid && fill_ready, fill_instr0 SHALL be written at wr_ptr and fill_instr1 at wr_ptr+1 (mod DEPTH), and wr_ptr SHALL advance by 2.
REQ-020 fill_valid while fill_ready=0 SHALL be ignored, with no state change and no data written.
REQ-021 Pop request: pop_req = 0 if consume=0; 1 if consume=1 and rollback=1; 2 if consume=1 and rollback=0.
REQ-022 Actual pop = min(pop_req, count); rd_ptr SHALL advance by the actual pop, and underflow SHALL never occur.
REQ-023 Simultaneous push and pop in one cycle: count_next = count + 2 - pop; both pointers update in that cycle.
REQ-024 instr1 and instr2 SHALL be combinational reads of entries rd_ptr and rd_ptr+1 (mod DEPTH).
REQ-025 valid1 = (count >= 1) and valid2 = (count >= 2); when a slot is invalid its instruction output SHALL be 32'h0 (a NOP bubble).
REQ-026 Zero latency: data pushed in cycle N SHALL appear on instr1/instr2 in cycle N+1.
REQ-027 Flush: when flush=1, the next state SHALL be rd_ptr=0, wr_ptr=0, count=0; flush has priority over a same-cycle push and pop, and that push is dropped.
REQ-028 stall_cycles SHALL increment by 1 in each cycle with consume=1, rollback=0 and count<2; it saturates at 16'hFFFF and is not cleared by flush.
REQ-029 Full boundary: at count=DEPTH-1 or DEPTH, fill_ready=0 even if a same-cycle pop would free space.

Reset
REQ-030 On rst_n=0, immediately and regardless of clk: rd_ptr=0, wr_ptr=0, count=0, stall_cycles=0, all storage entries cleared to 32'h0.
REQ-031 During reset the outputs SHALL be: instr1=0, instr2=0, valid1=0, valid2=0, fill_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard all queued data, with no partial push or pop completing; normal operation resumes on the first rising clk after rst_n returns to 1.

Verification
REQ-033 Reset, then push pair (A=32'h11, B=32'h22) -> next cycle instr1=32'h11, instr2=32'h22, valid1=1, valid2=1, count=2.
REQ-034 Queue holding A,B,C,D; consume=1, rollback=1 -> next cycle instr1=B, instr2=C, count=3; then consume=1, rollback=0 -> instr1=D, valid2=0, instr2=0, count=1.
REQ-035 DEPTH=8; push 4 pairs with no consume -> count=8, fill_ready=0; a 5th fill_valid is ignored; then consume=1, rollback=0 -> count=6, fill_ready=1.
REQ-036 Wrap-around: 10 consecutive push-2/pop-2 cycles -> pointers wrap past 7, the output order matches the input order exactly, and count stays at 2.
REQ-037 count=1 with consume=1, rollback=0 -> count=0, valid1=0, and stall_cycles increments by 1.
REQ-038 count=4 with flush=1 and fill_valid=1 in the same cycle -> next cycle count=0, valid1=0, and the pushed pair is absent; rst_n pulsed low mid-stream -> outputs are 0 before the next clk edge.
